digit_match_sequencer: RTL

- Sequences one shared per-pixel difference unit over a stored 11x11 digit image against 10 digit templates (0..9).
- Accumulates the 121 per-pixel differences per template, tracks the minimum total, and reports the best-matching digit.
- Sits between the frame-capture buffer and template ROM on one side, and the game logic that consumes the recognised digit on the other.

---
 rtl/digit_match_pkg.sv | 22 ++
 rtl/digit_match_sequencer_pixel_abs_diff.sv | 12 +
 rtl/digit_match_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/digit_match_pkg.sv
// Shared constants, FSM state type and no-match code for the digit match sequencer.
package digit_match_pkg;

    localparam int unsigned N_DIGITS = 10;
    localparam int unsigned SIDE     = 11;
    localparam int unsigned N_PIX    = SIDE * SIDE;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned SUM_W    = 15;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DIG_W    = 4;

    localparam logic [DIG_W-1:0] NO_MATCH = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/digit_match_sequencer_pixel_abs_diff.sv
// Combinational unsigned absolute difference of two pixels; the single shared difference unit.
module pixel_abs_diff
    import digit_match_pkg::*;
(
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] diff_c_o
);

    assign diff_c_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/digit_match_sequencer.sv
// Scans a stored 11x11 image against 10 templates and reports the digit with the smallest SAD.
// Optional DIGIT_MATCH_REJECT_EN adds reject_thresh_i and reports NO_MATCH above it.
module digit_match_sequencer
    import digit_match_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] img_addr_o,
    input  logic [PIX_W-1:0]  img_data_i,
    output logic [DIG_W-1:0]  tmpl_digit_o,
    output logic [ADDR_W-1:0] tmpl_addr_o,
    input  logic [PIX_W-1:0]  tmpl_data_i,
`ifdef DIGIT_MATCH_REJECT_EN
    input  logic [SUM_W-1:0]  reject_thresh_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [DIG_W-1:0]  digit_o,
    output logic [SUM_W-1:0]  best_score_o
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DIG_W-1:0]   tdig_q, tdig_d;
    logic               valid_q, valid_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   best_q, best_d;
    logic [DIG_W-1:0]   best_dig_q, best_dig_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DIG_W-1:0]   digit_q, digit_d;
    logic [SUM_W-1:0]   score_q, score_d;
    logic [PIX_W-1:0]   diff_c;
    logic               reject_c;

    pixel_abs_diff u_abs_diff (
        .a_i      (img_data_i),
        .b_i      (tmpl_data_i),
        .diff_c_o (diff_c)
    );

`ifdef DIGIT_MATCH_REJECT_EN
    assign reject_c = (best_q > reject_thresh_i);
`else
    assign reject_c = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tdig_q     <= '0;
            valid_q    <= 1'b0;
            acc_q      <= '0;
            best_q     <= '1;
            best_dig_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= '0;
            score_q    <= '1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tdig_q     <= tdig_d;
            valid_q    <= valid_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_dig_q <= best_dig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            score_q    <= score_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tdig_d     = tdig_q;
        valid_d    = (state_q == RUN) && !abort_i;
        acc_d      = acc_q;
        best_d     = best_q;
        best_dig_d = best_dig_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        digit_d    = digit_q;
        score_d    = score_q;

        // Data returned for the previous cycle's address is qualified by valid_q.
        if (valid_q) begin
            acc_d = acc_q + SUM_W'(diff_c);
        end

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    acc_d   = '0;
                    best_d  = '1;
                    tdig_d  = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (addr_q == ADDR_W'(N_PIX - 1)) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = CMP;
            end
            CMP: begin
                // Strict compare so ties keep the earlier (lower) digit.
                if (acc_q < best_q) begin
                    best_d     = acc_q;
                    best_dig_d = tdig_q;
                end
                acc_d = '0;
                if (tdig_q == DIG_W'(N_DIGITS - 1)) begin
                    state_d = DONE;
                end else begin
                    tdig_d  = tdig_q + DIG_W'(1);
                    addr_d  = '0;
                    state_d = RUN;
                end
            end
            DONE: begin
                digit_d = reject_c ? NO_MATCH : best_dig_q;
                score_d = best_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            digit_d = digit_q;
            score_d = score_q;
        end
    end

    assign img_addr_o   = addr_q;
    assign tmpl_addr_o  = addr_q;
    assign tmpl_digit_o = tdig_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign digit_o      = digit_q;
    assign best_score_o = score_q;

endmodule
